// File: rtl/alu_issue_arb.sv
// Issue arbiter sharing one registered 64-bit ALU between two requesters, with a registered valid/ready response port.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module alu_issue_arb #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RST_N,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_imm,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic            req0_wb,
    input  logic            req0_load,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_imm,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic            req1_wb,
    input  logic            req1_load,

    output logic            alu_imm,
    output logic [4:0]      alu_rd_i,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic            alu_wb,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_wb_en,
    input  logic [4:0]      alu_rd_o,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_res,
    output logic [4:0]      rsp_rd,
    output logic            rsp_wb_en,
    output logic            rsp_load
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              inflight_id_q;
    logic              inflight_load_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [XLEN-1:0]   rsp_res_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_wb_en_q;
    logic              rsp_load_q;

    logic              issue_win;
    logic              gnt_vld;
    logic              gnt_id;
    logic              gnt_load;

    // A new op may issue only when the response register is free or is being drained this cycle.
    always_comb begin
        issue_win = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
        gnt_vld   = issue_win && (req0_valid || req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_id    = !req0_valid;
`else
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = !req0_valid;
        end
`endif
        gnt_load   = gnt_id ? req1_load : req0_load;
        req0_ready = gnt_vld && !gnt_id;
        req1_ready = gnt_vld && gnt_id;
    end

    always_comb begin
        alu_imm    = 1'b0;
        alu_rd_i   = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_funct3 = '0;
        alu_funct7 = '0;
        alu_wb     = 1'b0;
        if (gnt_vld) begin
            if (gnt_id) begin
                alu_imm    = req1_imm;
                alu_rd_i   = req1_rd;
                alu_op1    = req1_op1;
                alu_op2    = req1_op2;
                alu_funct3 = req1_funct3;
                alu_funct7 = req1_funct7;
                alu_wb     = req1_wb;
            end else begin
                alu_imm    = req0_imm;
                alu_rd_i   = req0_rd;
                alu_op1    = req0_op1;
                alu_op2    = req0_op2;
                alu_funct3 = req0_funct3;
                alu_funct7 = req0_funct7;
                alu_wb     = req0_wb;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q         <= S_IDLE;
            last_grant_q    <= 1'b1;
            inflight_id_q   <= 1'b0;
            inflight_load_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_res_q       <= '0;
            rsp_rd_q        <= '0;
            rsp_wb_en_q     <= 1'b0;
            rsp_load_q      <= 1'b0;
        end else begin
            if (gnt_vld) begin
                inflight_id_q   <= gnt_id;
                inflight_load_q <= gnt_load;
                last_grant_q    <= gnt_id;
            end
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        state_q <= S_WAIT;
                    end
                end
                // ALU has a one-cycle latency, so its result is valid while we sit in WAIT.
                S_WAIT: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_res_q   <= alu_res;
                    rsp_wb_en_q <= alu_wb_en;
                    rsp_rd_q    <= alu_rd_o;
                    rsp_id_q    <= inflight_id_q;
                    rsp_load_q  <= inflight_load_q;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= gnt_vld ? S_WAIT : S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_wb_en = rsp_wb_en_q;
    assign rsp_load  = rsp_load_q;

endmodule

// File: doc/alu_issue_arb.md
Name: alu_issue_arb

Overview:
- Shares the single registered 64-bit ALU between two issue requesters: req0 (main integer pipe) and req1 (auxiliary/microcode sequencer).
- Arbitrates between them, drives the ALU operand/control inputs, and tracks the in-flight operation.
- Captures the ALU result one cycle after issue.
- Presents the result on a valid/ready response port tagged with the source requester ID.

Parameters:
- XLEN, 64, operand/result width; must match the ALU datapath.

Ports:
- CLK  in  1  clock
- RST_N  in  1  synchronous active-low reset
- reqN_valid  in  1  (N=0,1) requester N has an op
- reqN_ready  out  1  requester N op accepted this cycle
- reqN_imm  in  1  immediate-form flag
- reqN_rd  in  5  destination register
- reqN_op1, reqN_op2  in  XLEN  operands
- reqN_funct3  in  3  ALU function
- reqN_funct7  in  7  ALU function modifier
- reqN_wb  in  1  write-back request
- reqN_load  in  1  load flag sideband
- alu_imm, alu_rd_i, alu_op1, alu_op2, alu_funct3, alu_funct7, alu_wb  out  (as above)  ALU inputs
- alu_res  in  XLEN  registered ALU result
- alu_wb_en  in  1  registered ALU write-back enable
- alu_rd_o  in  5  registered ALU destination
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  source requester of response
- rsp_res  out  XLEN  result
- rsp_rd  out  5  destination
- rsp_wb_en  out  1  write-back enable
- rsp_load  out  1  load flag

Behaviour:
- State machine: IDLE, WAIT, RESP. Reset (RST_N=0 at a CLK edge) forces:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_rd=0, rsp_wb_en=0, rsp_load=0, last_grant=1.
  - Any in-flight op is dropped.
- Issue window (combinational): state==IDLE, or state==RESP && rsp_ready.
- Arbitration (round-robin) inside the issue window:
  - Only one reqN_valid: grant N.
  - Both valid: grant the requester != last_grant.
  - reqN_ready=1 only for the granted N; at most one ready per cycle.
  - Outside the window, or with no valid request, both ready=0.
- ALU drive:
  - On a grant, the alu_* outputs are a combinational mux of the granted requester's fields.
  - Otherwise alu_wb=0 and all other alu_* outputs are 0, so the ALU registers wb_en=0 on idle cycles.
- Transitions:
  - IDLE: grant -> WAIT, else stay.
  - WAIT: always -> RESP. alu_res/alu_wb_en/alu_rd_o are valid this cycle (ALU latency 1). At the WAIT->RESP edge, capture rsp_res<=alu_res, rsp_wb_en<=alu_wb_en, rsp_rd<=alu_rd_o, rsp_id<=inflight_id, rsp_load<=inflight_load, rsp_valid<=1.
  - RESP: rsp_ready && grant -> WAIT, rsp_valid<=0. rsp_ready && no grant -> IDLE, rsp_valid<=0. !rsp_ready -> stay; all rsp_* are held stable.
- At a grant edge, latch inflight_id<=N, inflight_load<=reqN_load, last_grant<=N.
- Latency: grant in cycle T -> rsp_valid high from cycle T+2.
- Peak throughput: one op per 2 cycles (back-to-back when rsp_ready is high in RESP).
- Requesters must hold their fields stable while reqN_valid && !reqN_ready. The arbiter does not buffer requests.
- Simultaneous rsp_ready and a new grant in RESP are legal; the new op's result never overwrites the old one before the handshake.
- rsp_* are registered outputs. No combinational path from rsp_ready to rsp_*.
- Reset mid-WAIT/RESP: the result is discarded and no response is emitted.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins when both are valid. last_grant is still updated but ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset then req0 only (op1=5, op2=3, funct3=000, funct7=0, rd=7, wb=1) granted at T -> rsp_valid at T+2, rsp_res=8, rsp_rd=7, rsp_id=0, rsp_wb_en=1.
- Both valid every window, rsp_ready=1 -> grants alternate 0,1,0,1 starting with req0. With ALU_ARB_FIXED_PRIO_EN: 0,0,0,0 and req1 never ready.
- req1 SUB (funct7=0100000, op1=3, op2=5), rsp_ready=0 for 4 cycles -> rsp_res=0xFFFFFFFFFFFFFFFE held stable, rsp_id=1, no further reqN_ready until the handshake.
- In RESP with rsp_ready=1 and req0 valid -> same-cycle handshake and grant. Next response appears 2 cycles later; the previous rsp_res is unaffected until then.
- Assert RST_N=0 during WAIT -> next cycle state IDLE, rsp_valid=0; no stale response after reset release.
- req0 with load=1, wb=0 -> alu_wb driven 0, rsp_load=1, rsp_wb_en=0. Idle cycles show alu_wb=0.
